// File: rtl/wb_ram_pkg.sv
// Shared constants, latency selector and lane helper for the Wishbone RAM slave.
package wb_ram_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic {
    LAT1 = 1'b0,
    LAT2 = 1'b1
  } lat_e;

  function automatic int unsigned lanes(input int unsigned data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/ram_bytewr.sv
// Single-port RAM with per-byte-lane write enables and a registered read port.
module ram_bytewr
  import wb_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 'h400,
  parameter int unsigned AW         = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          we,
  input  logic                          clr,
  input  logic [AW-1:0]                 adr,
  input  logic [lanes(DATA_WIDTH)-1:0]  be,
  input  logic [DATA_WIDTH-1:0]         wdat,
  output logic [DATA_WIDTH-1:0]         rdat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdat_d, rdat_q;

  // An out-of-range access zeroes the read register so dat_o reads 0 with err.
  always_comb begin
    rdat_d = rdat_q;
    if (clr) begin
      rdat_d = '0;
    end else if (en && !we) begin
      rdat_d = mem[adr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned i = 0; i < lanes(DATA_WIDTH); i++) begin
        if (be[i]) begin
          mem[adr][i*LANE_W +: LANE_W] <= wdat[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/wb_ram_pipe.sv
// Wishbone B4 pipelined RAM slave: wait states, range check, ack/err pipeline
// and optional output register around the byte-writable array.
module wb_ram_pipe
  import wb_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DEPTH        = 'h400,
  parameter int unsigned ADR_WIDTH    = 16,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cyc,
  input  logic                          stb,
  input  logic                          we,
  input  logic [ADR_WIDTH-1:0]          adr,
  input  logic [lanes(DATA_WIDTH)-1:0]  sel,
  input  logic [DATA_WIDTH-1:0]         dat_i,
  output logic [DATA_WIDTH-1:0]         dat_o,
  output logic                          ack,
  output logic                          err,
  output logic                          stall
);

  localparam int unsigned          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam lat_e                 LAT       = (READ_LATENCY == 2) ? LAT2 : LAT1;
  localparam logic [ADR_WIDTH:0]   DEPTH_W   = (ADR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]           WAIT_INIT = 4'(WAIT_CYCLES);

  logic                  valid, accept, in_range, acc_ok, acc_bad;
  logic [3:0]            wcnt_d, wcnt_q;
  logic                  p1_ack_d, p1_ack_q, p1_err_d, p1_err_q, p1_rd_d, p1_rd_q;
  logic                  ack_d, ack_q, err_d, err_q;
  logic [DATA_WIDTH-1:0] dout_d, dout_q, rdat;

  assign valid    = cyc & stb;
  assign stall    = valid & (wcnt_q != '0);
  assign accept   = valid & ~stall & ~rst;
  assign in_range = {1'b0, adr} < DEPTH_W;
  assign acc_ok   = accept & in_range;
  assign acc_bad  = accept & ~in_range;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!cyc || accept) begin
      wcnt_d = WAIT_INIT;
    end else if (stall) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  // With LAT2 the stage-1 flags carry each response one extra cycle so that
  // ack/err line up with the output register.
  always_comb begin
    p1_ack_d = 1'b0;
    p1_err_d = 1'b0;
    p1_rd_d  = 1'b0;
    ack_d    = acc_ok;
    err_d    = acc_bad;
    dout_d   = dout_q;
    if (LAT == LAT2) begin
      p1_ack_d = acc_ok;
      p1_err_d = acc_bad;
      p1_rd_d  = acc_ok & ~we;
      ack_d    = p1_ack_q;
      err_d    = p1_err_q;
      if (p1_rd_q) begin
        dout_d = rdat;
      end else if (p1_err_q) begin
        dout_d = '0;
      end
    end
    if (!cyc) begin
      p1_ack_d = 1'b0;
      p1_err_d = 1'b0;
      p1_rd_d  = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q   <= WAIT_INIT;
      p1_ack_q <= 1'b0;
      p1_err_q <= 1'b0;
      p1_rd_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      p1_ack_q <= p1_ack_d;
      p1_err_q <= p1_err_d;
      p1_rd_q  <= p1_rd_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  ram_bytewr #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_ok),
    .we   (we),
    .clr  (acc_bad),
    .adr  (adr[AW-1:0]),
    .be   (sel),
    .wdat (dat_i),
    .rdat (rdat)
  );

  assign ack   = ack_q & cyc;
  assign err   = err_q & cyc;
  assign dat_o = (LAT == LAT2) ? dout_q : rdat;

endmodule
